rng_roll_ctrl: RTL and testbench
================================

# rng_roll_ctrl

Sequencing controller for the lab random-number display: on a start pulse it runs a "dice roll", updating a 4-bit random value at progressively longer intervals until it settles, then reports completion. A free-running 16-bit LFSR supplies the values, so the result depends on when the user presses start. It sits between the debounced key inputs and the 7-segment/LED output path.

## Interface
- P_INIT, 4: cycles between the first and second value updates; legal range ≥1.
- P_STEP, 2: cycles added to the interval after each update; legal range ≥1.
- P_MAX, 40: largest interval allowed; legal range P_INIT ≤ P_MAX ≤ 255−P_STEP.
- P_SEED, 16'hACE1: LFSR reset value; must be nonzero.
- i_clk, input, 1: clock; all state updates on its rising edge.
- i_rst_n, input, 1: reset, asynchronous, active-low.
- i_start, input, 1: single-cycle start pulse.
- i_stop, input, 1: single-cycle request to end the current roll early.
- o_random_out, output, 4: current displayed value.
- o_busy, output, 1: high while a roll is in progress.
- o_done, output, 1: one-cycle pulse when a roll ends.
- o_prev_out, output, 4: result of the previous completed roll. Present only with RNG_PREV_EN.

## Operation
- LFSR lfsr_r[15:0] uses polynomial x^16+x^14+x^13+x^11+1.
  - Feedback fb = lfsr_r[15]^lfsr_r[13]^lfsr_r[12]^lfsr_r[10].
  - Next value is {lfsr_r[14:0], fb}.
  - Advances every cycle in every state. Reset value is P_SEED.
- Sample value is lfsr_r[3:0], taken at the edge where the update occurs (the pre-advance value).
- Internal registers:
  - state_r ∈ {S_IDLE, S_RUN}
  - period_r[7:0]: current interval
  - cnt_r[7:0]: down-counter within the interval
- S_IDLE, i_start=1:
  - Set o_random_out to the sample.
  - Set period_r=P_INIT and cnt_r=P_INIT−1.
  - Enter S_RUN; o_busy becomes 1.
  - i_stop is ignored in S_IDLE.
- S_RUN with cnt_r≠0 and i_stop=0: cnt_r decrements by 1; o_random_out holds.
- S_RUN with cnt_r==0 (an update):
  - Set o_random_out to the sample.
  - Compute next = period_r+P_STEP in 9 bits.
  - If next > P_MAX, the roll ends: enter S_IDLE, o_busy→0, o_done→1 for one cycle.
  - Otherwise set period_r=next and cnt_r=next−1.
- S_RUN with i_stop=1: final update now, whatever cnt_r holds.
  - Set o_random_out to the sample, enter S_IDLE, pulse o_done.
  - If cnt_r==0 in the same cycle, exactly one update and one o_done pulse occur.
- i_start in S_RUN is ignored; the roll is not restarted.
- The final value holds in S_IDLE until the next start.
- Reset values, applied at any time including mid-roll:
  - o_random_out=0, o_busy=0, o_done=0, o_prev_out=0.
  - state S_IDLE, period_r=0, cnt_r=0, lfsr_r=P_SEED.
  - No o_done pulse is generated by reset.

## Timing
- Start latency is one edge: o_busy and the first value appear at the edge that samples i_start.
- The update intervals are P_INIT, P_INIT+P_STEP, … up to the largest value ≤ P_MAX.
- With default parameters:
  - Intervals are 4,6,…,40 (19 intervals), giving 20 values including the first.
  - The final update occurs 418 cycles after the start edge.
- o_done rises at the same edge as the final update and is high for exactly one cycle.
- o_busy falls at that same edge.
- A new i_start is accepted in the cycle o_done is high, since the state is already S_IDLE.
- i_stop latency is one edge.

## Configuration
- RNG_PREV_EN defined:
  - o_prev_out exists.
  - At each roll-ending edge, o_prev_out takes the old o_random_out value (the second-to-last displayed value) before the final value replaces it. This holds for both natural end and i_stop.
- RNG_PREV_EN undefined: the port and its register are absent; all other behaviour is identical.

## Test plan
- Reset check: assert i_rst_n=0 mid-roll → o_random_out=0, o_busy=0, o_done=0 immediately; lfsr_r=16'hACE1 after release.
- Full roll with defaults: start in the first cycle after reset.
  - First value = 4'h1, the low nibble of the seed.
  - Exactly 20 value updates, o_done pulses once, 418 cycles after the start edge.
  - o_busy is high throughout the roll.
- Early stop: i_stop 10 cycles after start → final update at the next edge, o_done one cycle, o_busy=0, value then holds for 100 cycles.
- Ignored inputs:
  - i_start repeatedly during S_RUN → timeline unchanged, 418 cycles.
  - i_stop in S_IDLE → no o_done.
- Coincident stop and update: i_stop on the cnt_r==0 cycle of the 4-cycle interval → a single update and a single o_done pulse.
- With RNG_PREV_EN: two back-to-back rolls → after the second ends, o_prev_out equals the second roll's second-to-last value; o_start accepted during the o_done cycle.

Source files
------------

// File: rtl/rng_roll_ctrl.sv
// Dice-roll sequencer: a free-running 16-bit LFSR feeds a 4-bit value that is refreshed at widening intervals.
// Define RNG_PREV_EN to add o_prev_out, the second-to-last value shown by the most recent roll.
module rng_roll_ctrl #(
  parameter int unsigned P_INIT = 4,
  parameter int unsigned P_STEP = 2,
  parameter int unsigned P_MAX  = 40,
  parameter logic [15:0] P_SEED = 16'hACE1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  output logic [3:0] o_random_out,
  output logic       o_busy,
`ifdef RNG_PREV_EN
  output logic       o_done,
  output logic [3:0] o_prev_out
`else
  output logic       o_done
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_r, state_n;
  logic [15:0] lfsr_r;
  logic        fb;
  logic [7:0]  period_r, period_n;
  logic [7:0]  cnt_r, cnt_n;
  logic [3:0]  random_r, random_n;
  logic        done_r, done_n;
  logic        roll_end;
  logic [8:0]  next_period;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  assign fb          = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];
  assign next_period = {1'b0, period_r} + 9'(P_STEP);

  always_comb begin
    state_n  = state_r;
    period_n = period_r;
    cnt_n    = cnt_r;
    random_n = random_r;
    done_n   = 1'b0;
    roll_end = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          random_n = lfsr_r[3:0];
          period_n = 8'(P_INIT);
          cnt_n    = 8'(P_INIT - 1);
          state_n  = S_RUN;
        end
      end
      S_RUN: begin
        // A stop coinciding with a scheduled update still yields just one update
        if (i_stop) begin
          random_n = lfsr_r[3:0];
          state_n  = S_IDLE;
          done_n   = 1'b1;
          roll_end = 1'b1;
        end else if (cnt_r == 8'd0) begin
          random_n = lfsr_r[3:0];
          if (next_period > 9'(P_MAX)) begin
            state_n  = S_IDLE;
            done_n   = 1'b1;
            roll_end = 1'b1;
          end else begin
            period_n = next_period[7:0];
            cnt_n    = next_period[7:0] - 8'd1;
          end
        end else begin
          cnt_n = cnt_r - 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r  <= S_IDLE;
      lfsr_r   <= P_SEED;
      period_r <= 8'd0;
      cnt_r    <= 8'd0;
      random_r <= 4'd0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      lfsr_r   <= {lfsr_r[14:0], fb};
      period_r <= period_n;
      cnt_r    <= cnt_n;
      random_r <= random_n;
      done_r   <= done_n;
    end
  end

`ifdef RNG_PREV_EN
  logic [3:0] prev_r;

  // Captures the value being replaced by the roll's final update
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_r <= 4'd0;
    end else if (roll_end) begin
      prev_r <= random_r;
    end
  end

  assign o_prev_out = prev_r;
`else
  logic unused_roll_end;
  assign unused_roll_end = roll_end;
`endif

  assign o_random_out = random_r;
  assign o_busy       = (state_r == S_RUN);
  assign o_done       = done_r;

endmodule

// File: tb/tb_rng_roll_ctrl.sv
// Randomized self-checking bench for rng_roll_ctrl against a timeline-level roll model.
module tb_rng_roll_ctrl;
  localparam int unsigned P_INIT = 4;
  localparam int unsigned P_STEP = 2;
  localparam int unsigned P_MAX  = 40;
  localparam logic [15:0] P_SEED = 16'hACE1;
  localparam int FULL_LEN = 418;
  localparam int FULL_UPD = 20;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] random_out;
  logic       busy;
  logic       done;
  logic [3:0] prev_out;

  int tests = 0;
  int fails = 0;

  rng_roll_ctrl #(
    .P_INIT(P_INIT), .P_STEP(P_STEP), .P_MAX(P_MAX), .P_SEED(P_SEED)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_stop      (stop),
    .o_random_out(random_out),
    .o_busy      (busy),
`ifdef RNG_PREV_EN
    .o_done      (done),
    .o_prev_out  (prev_out)
`else
    .o_done      (done)
`endif
  );

`ifndef RNG_PREV_EN
  assign prev_out = 4'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sequence of the free-running generator, straight from the polynomial
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= P_SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  // Drives one roll and checks every cycle against an update schedule built from the interval list.
  task automatic run_roll(input string name, input bit no_wait, input int stop_k, input bit spam,
                          output logic [3:0] first_v, output logic [3:0] last_v,
                          output logic [3:0] pen_v, output int upd, output int end_k);
    logic [3:0] cur, pen, smp;
    int interval, next_upd, k;
    bit ended;
    if (!no_wait) @(negedge clk);
    start = 1'b1;
    cur = m_lfsr[3:0];
    pen = cur;
    first_v = cur;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (random_out !== cur || busy !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s start: out=%h busy=%b done=%b, want out=%h busy=1 done=0",
               name, random_out, busy, done, cur);
    end
    interval = P_INIT;
    next_upd = P_INIT;
    upd = 1;
    k = 0;
    ended = 1'b0;
    end_k = -1;
    while (!ended && k < 1000) begin
      k++;
      stop  = (k == stop_k);
      start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      smp = m_lfsr[3:0];
      if (k == stop_k || k == next_upd) begin
        pen = cur;
        cur = smp;
        upd++;
        if (k == stop_k || interval + P_STEP > P_MAX) begin
          ended = 1'b1;
          end_k = k;
        end else begin
          interval += P_STEP;
          next_upd = k + interval;
        end
      end
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      tests++;
      if (random_out !== cur || busy !== ~ended || done !== ended) begin
        fails++;
        $display("FAIL %s cycle %0d: out=%h busy=%b done=%b, want out=%h busy=%b done=%b",
                 name, k, random_out, busy, done, cur, ~ended, ended);
      end
    end
    if (!ended) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: roll still running after %0d cycles, want end", name, k);
    end
    last_v = cur;
    pen_v = pen;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_midroll_busy: busy=%b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (random_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || prev_out !== 4'd0) begin
      fails++;
      $display("FAIL reset_async: out=%h busy=%b done=%b prev=%h, want 0 0 0 0",
               random_out, busy, done, prev_out);
    end
    repeat (2) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold: done=%b busy=%b, want 0 0", done, busy);
      end
    end
    rst_n = 1'b1;
    tests++;
    if (dut.lfsr_r !== 16'hACE1) begin
      fails++;
      $display("FAIL reset_lfsr: lfsr=%h, want ace1", dut.lfsr_r);
    end
  endtask

  task automatic test_full_roll;
    logic [3:0] f, l, p;
    int u, e;
    run_roll("full", 1'b1, -1, 1'b0, f, l, p, u, e);
    tests++;
    if (f !== 4'h1) begin
      fails++;
      $display("FAIL full_first: first=%h, want 1", f);
    end
    tests++;
    if (u != FULL_UPD || e != FULL_LEN) begin
      fails++;
      $display("FAIL full_timeline: updates=%0d end=%0d, want %0d %0d", u, e, FULL_UPD, FULL_LEN);
    end
    repeat (5) begin
      @(negedge clk);
      tests++;
      if (random_out !== l || done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL full_hold: out=%h done=%b busy=%b, want %h 0 0", random_out, done, busy, l);
      end
    end
  endtask

  task automatic test_early_stop;
    logic [3:0] f, l, p;
    int u, e;
    run_roll("stop10", 1'b0, 10, 1'b0, f, l, p, u, e);
    tests++;
    if (e != 10) begin
      fails++;
      $display("FAIL stop10_end: end=%0d, want 10", e);
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      tests++;
      if (random_out !== l || done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL stop10_hold %0d: out=%h done=%b busy=%b, want %h 0 0",
                 i, random_out, done, busy, l);
      end
    end
  endtask

  task automatic test_ignored_inputs;
    logic [3:0] f, l, p;
    int u, e;
    run_roll("spam_start", 1'b0, -1, 1'b1, f, l, p, u, e);
    tests++;
    if (u != FULL_UPD || e != FULL_LEN) begin
      fails++;
      $display("FAIL spam_timeline: updates=%0d end=%0d, want %0d %0d", u, e, FULL_UPD, FULL_LEN);
    end
    for (int i = 0; i < 20; i++) begin
      stop = 1'($urandom_range(0, 1));
      @(negedge clk);
      stop = 1'b0;
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || random_out !== l) begin
        fails++;
        $display("FAIL idle_stop %0d: done=%b busy=%b out=%h, want 0 0 %h",
                 i, done, busy, random_out, l);
      end
    end
  endtask

  task automatic test_coincident;
    logic [3:0] f, l, p;
    int u, e;
    run_roll("coincident", 1'b0, 4, 1'b0, f, l, p, u, e);
    tests++;
    if (u != 2 || e != 4) begin
      fails++;
      $display("FAIL coincident_count: updates=%0d end=%0d, want 2 4", u, e);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || random_out !== l) begin
      fails++;
      $display("FAIL coincident_single: done=%b out=%h, want 0 %h", done, random_out, l);
    end
  endtask

  task automatic test_random_rolls;
    logic [3:0] f, l, p;
    int u, e, sk, want_e;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      sk = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, FULL_LEN));
      want_e = (sk < 0) ? FULL_LEN : sk;
      run_roll("random", 1'b0, sk, 1'b0, f, l, p, u, e);
      tests++;
      if (e != want_e) begin
        fails++;
        $display("FAIL random_end %0d: end=%0d, want %0d", r, e, want_e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] f, la, pa, lb, pb;
    int u, e;
    run_roll("b2b_a", 1'b0, -1, 1'b0, f, la, pa, u, e);
`ifdef RNG_PREV_EN
    tests++;
    if (prev_out !== pa) begin
      fails++;
      $display("FAIL b2b_prev_a: prev=%h, want %h", prev_out, pa);
    end
`endif
    run_roll("b2b_b", 1'b1, int'($urandom_range(30, 300)), 1'b0, f, lb, pb, u, e);
`ifdef RNG_PREV_EN
    tests++;
    if (prev_out !== pb) begin
      fails++;
      $display("FAIL b2b_prev_b: prev=%h, want %h", prev_out, pb);
    end
`endif
    @(negedge clk);
    tests++;
    if (random_out !== lb || busy !== 1'b0) begin
      fails++;
      $display("FAIL b2b_hold: out=%h busy=%b, want %h 0", random_out, busy, lb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    test_reset();
    test_full_roll();
    test_early_stop();
    test_ignored_inputs();
    test_coincident();
    test_random_rolls();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
